// File: rtl/bcd_display_driver_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_driver_pkg
// Shared definitions for the BCD display driver. It holds the digit codes
// understood by the downstream seven-segment decoder, the anode position
// indices, the conversion FSM state type, the committed-display record, and
// one double-dabble step.
// -----------------------------------------------------------------------------
package bcd_display_driver_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  DIG_MINUS  = 4'hA;   // decoder code for '-'
    localparam int          DD_STEPS   = 8;      // one step per magnitude bit

    // Anode / scan positions.
    localparam int POS_ONES = 0;
    localparam int POS_TENS = 1;
    localparam int POS_HUND = 2;
    localparam int POS_SIGN = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    // Value currently on the display: sign flag plus three BCD digits.
    typedef struct packed {
        logic       neg;
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } disp_t;

    // One double-dabble step on {bcd[11:0], bin[7:0]}: add 3 to every BCD
    // nibble that is 5 or more, then shift the whole vector left by one bit.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[8 + 4*i +: 4] >= 4'd5)
                r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_display_driver_bin2bcd.sv
// -----------------------------------------------------------------------------
// bcd_display_driver_bin2bcd
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble), one step
// per clock.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start_i   load mag_i and begin; steps run on the following 8 edges
//   mag_i     8-bit unsigned magnitude
//   bcd_o     {hundreds, tens, ones}; final once the last step has executed
//   done_o    high in the cycle whose closing edge performs the last step
// -----------------------------------------------------------------------------
module bcd_display_driver_bin2bcd
    import bcd_display_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  mag_i,
    output logic [11:0] bcd_o,
    output logic        done_o
);

    logic [19:0] sh_q;
    logic [2:0]  cnt_q;
    logic        run_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            sh_q  <= {12'd0, mag_i};
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sh_q  <= dd_step(sh_q);
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'(DD_STEPS - 1))
                run_q <= 1'b0;
        end
    end

    assign bcd_o  = sh_q[19:8];
    assign done_o = run_q && (cnt_q == 3'(DD_STEPS - 1));

endmodule

// File: rtl/bcd_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_display_driver
// Takes a byte from the UART receiver, converts it to sign + 3 BCD digits and
// time-multiplexes the four digit positions onto a single seven-segment
// decoder input. Anodes are delayed one cycle to line up with the decoder's
// registered output.
// Parameters:
//   SIGNED       1: data_in is two's complement; 0: unsigned, sign never lit
//   REFRESH_DIV  clk cycles each position stays selected (>= 2)
//   AN_ACT_LOW   1: anodes active-low; 0: active-high
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   data_in      byte to display, sampled when data_valid is accepted
//   data_valid   1-cycle strobe; ignored (and flagged) while busy
//   busy         conversion in progress
//   overrun      sticky: a strobe arrived while busy; cleared by next accept
//   digit_code   to decoder 'in' (0-9, 4'hA = minus)
//   digit_en     to decoder 'en'
//   an           digit anodes [3]=sign [2]=hundreds [1]=tens [0]=ones
// -----------------------------------------------------------------------------
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter bit SIGNED      = 1'b1,
    parameter int REFRESH_DIV = 50000,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       busy,
    output logic       overrun,
    output logic [3:0] digit_code,
    output logic       digit_en,
    output logic [3:0] an
);

    localparam int                     DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0]  AN_OFF   = AN_ACT_LOW ? '1 : '0;

    // ---------------------------------------------------------------- convert
    conv_state_e state_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        overrun_q;
    logic        neg_q;
    disp_t       disp_q;

    logic        neg_load;
    logic [7:0]  mag_load;
    logic        core_start;
    logic [11:0] core_bcd;
    logic        core_done;

    // Two's-complement negate in 8 bits; -128 maps to 8'h80, i.e. magnitude 128.
    assign neg_load   = SIGNED && data_q[7];
    assign mag_load   = neg_load ? (~data_q + 8'd1) : data_q;
    assign core_start = (state_q == ST_LOAD);

    bcd_display_driver_bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (core_start),
        .mag_i   (mag_load),
        .bcd_o   (core_bcd),
        .done_o  (core_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            neg_q     <= 1'b0;
            disp_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (data_valid) begin
                        data_q    <= data_in;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    neg_q   <= neg_load;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (core_done)
                        state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_q  <= {neg_q, core_bcd};
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Any strobe outside IDLE, COMMIT included, is dropped.
            if (data_valid && (state_q != ST_IDLE))
                overrun_q <= 1'b1;
        end
    end

    // ------------------------------------------------------- blanking / select
    logic [DIV_W-1:0]       div_q;
    logic [1:0]             idx_q;
    logic                   wrapped_q;
    logic [NUM_DIGITS-1:0]  lit;
    logic [3:0]             code_sel;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lit           = '0;
        lit[POS_ONES] = 1'b1;
        lit[POS_TENS] = (disp_q.hund != 4'd0) || (disp_q.tens != 4'd0);
        lit[POS_HUND] = (disp_q.hund != 4'd0);
        lit[POS_SIGN] = disp_q.neg;
    end

    always_comb begin
        code_sel = disp_q.ones;
        case (idx_q)
            2'(POS_TENS): code_sel = disp_q.tens;
            2'(POS_HUND): code_sel = disp_q.hund;
            2'(POS_SIGN): code_sel = disp_q.neg ? DIG_MINUS : 4'd0;
            default:      code_sel = disp_q.ones;
        endcase
    end

    // -------------------------------------------------------------------- scan
    logic [3:0]             digit_code_q;
    logic                   digit_en_q;
    logic [1:0]             idx_p_q;     // idx that produced digit_code_q
    logic                   lit_p_q;
    logic [NUM_DIGITS-1:0]  an_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            wrapped_q    <= 1'b0;
            digit_code_q <= '0;
            digit_en_q   <= 1'b0;
            idx_p_q      <= '0;
            lit_p_q      <= 1'b0;
            an_q         <= AN_OFF;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q     <= '0;
                idx_q     <= idx_q + 2'd1;
                wrapped_q <= 1'b1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            // Decoder input stage.
            digit_code_q <= code_sel;
            digit_en_q   <= wrapped_q;
            idx_p_q      <= idx_q;
            lit_p_q      <= lit[idx_q];

            // Anode stage, one cycle behind to match the decoder register.
            // XOR with AN_OFF turns the one-hot into the active-low form.
            if (digit_en_q && lit_p_q)
                an_q <= (NUM_DIGITS'(1) << idx_p_q) ^ AN_OFF;
            else
                an_q <= AN_OFF;
        end
    end

    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign digit_code = digit_code_q;
    assign digit_en   = digit_en_q;
    assign an         = an_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_driver
// Two instances (signed and unsigned), REFRESH_DIV=4, active-low anodes.
// Expected displays are computed from the input byte with integer arithmetic,
// queued when a byte is accepted and popped when busy falls. The displayed
// value is then reconstructed from the anode/digit_code scan: each active
// anode must pair with the code and enable seen on the previous cycle.
// -----------------------------------------------------------------------------
module tb_bcd_display_driver;

    typedef struct {
        bit neg;
        int h;
        int t;
        int o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in_s, data_in_u;
    logic       valid_s, valid_u;
    logic       busy_s, busy_u, ovr_s, ovr_u, en_s, en_u;
    logic [3:0] code_s, code_u, an_s, an_u;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bcd_display_driver #(.SIGNED(1'b1), .REFRESH_DIV(4), .AN_ACT_LOW(1'b1)) dut_s (
        .clk(clk), .rst(rst), .data_in(data_in_s), .data_valid(valid_s),
        .busy(busy_s), .overrun(ovr_s), .digit_code(code_s), .digit_en(en_s), .an(an_s)
    );

    bcd_display_driver #(.SIGNED(1'b0), .REFRESH_DIV(4), .AN_ACT_LOW(1'b1)) dut_u (
        .clk(clk), .rst(rst), .data_in(data_in_u), .data_valid(valid_u),
        .busy(busy_u), .overrun(ovr_u), .digit_code(code_u), .digit_en(en_u), .an(an_u)
    );

    function automatic exp_t model(input logic [7:0] b, input bit signed_mode);
        exp_t e;
        int   v;
        int   m;
        v     = signed_mode ? int'($signed(b)) : int'(b);
        e.neg = (v < 0);
        m     = (v < 0) ? -v : v;
        e.h   = m / 100;
        e.t   = (m / 10) % 10;
        e.o   = m % 10;
        return e;
    endfunction

    task automatic sample(input bit uns, output logic b, output logic ov,
                          output logic [3:0] c, output logic e, output logic [3:0] a);
        if (uns) begin
            b = busy_u; ov = ovr_u; c = code_u; e = en_u; a = an_u;
        end else begin
            b = busy_s; ov = ovr_s; c = code_s; e = en_s; a = an_s;
        end
    endtask

    task automatic drive(input bit uns, input logic [7:0] d, input logic v);
        if (uns) begin
            data_in_u = d; valid_u = v;
        end else begin
            data_in_s = d; valid_s = v;
        end
    endtask

    // Strobe one byte; returns #1 after the sampling edge.
    task automatic send(input bit uns, input logic [7:0] d, input bit push);
        drive(uns, d, 1'b1);
        @(posedge clk); #1;
        drive(uns, d, 1'b0);
        if (push) sb_q.push_back(model(d, !uns));
    endtask

    // Cycles until busy is low, bounded; a timeout counts as a failure.
    task automatic wait_idle(input bit uns, input string name, output int n);
        logic b, ov, e;
        logic [3:0] c, a;
        n = 0;
        sample(uns, b, ov, c, e, a);
        while (b && n < 40) begin
            @(posedge clk); #1;
            n++;
            sample(uns, b, ov, c, e, a);
        end
        if (b) begin
            checks++; failures++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", name, b, n);
        end
    endtask

    task automatic check_display(input bit uns, input exp_t e, input string name);
        logic       b, ov, en, p_en;
        logic [3:0] c, a, p_code, act, seen, exp_mask;
        logic [3:0] exp_code [4];
        int         lag_err;
        int         p;
        exp_code[3] = 4'hA;
        exp_code[2] = 4'(e.h);
        exp_code[1] = 4'(e.t);
        exp_code[0] = 4'(e.o);
        exp_mask    = {e.neg, (e.h != 0), (e.h != 0) || (e.t != 0), 1'b1};
        repeat (3) @(posedge clk);
        #1;
        sample(uns, b, ov, p_code, p_en, a);
        seen    = '0;
        lag_err = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            sample(uns, b, ov, c, en, a);
            act = ~a;
            if (act != 4'd0) begin
                if ($countones(act) != 1) begin
                    lag_err++;
                end else begin
                    p = 0;
                    for (int k = 0; k < 4; k++) if (act[k]) p = k;
                    seen[p] = 1'b1;
                    if (!p_en || p_code !== exp_code[p]) lag_err++;
                end
            end
            p_code = c;
            p_en   = en;
        end
        checks++;
        if (seen !== exp_mask) begin
            failures++;
            $display("FAIL %s_lit: anodes seen %b, required %b", name, seen, exp_mask);
        end
        checks++;
        if (lag_err != 0) begin
            failures++;
            $display("FAIL %s_codes: %0d bad anode/code pairings, required 0 (digits %0d%0d%0d neg=%0b)",
                     name, lag_err, e.h, e.t, e.o, e.neg);
        end
    endtask

    // Accept one byte, check the 10-cycle busy window, then the display.
    task automatic convert(input bit uns, input logic [7:0] d, input string name);
        int   n;
        exp_t e;
        send(uns, d, 1'b1);
        wait_idle(uns, name, n);
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL %s_busy_len: busy cycles %0d, required 10", name, n);
        end
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_sb: queue empty, required 1 entry", name);
        end else begin
            e = sb_q.pop_front();
            check_display(uns, e, name);
        end
    endtask

    task automatic check_reset_outputs(input bit uns, input string name);
        logic b, ov, e;
        logic [3:0] c, a;
        sample(uns, b, ov, c, e, a);
        checks++;
        if ({b, ov, c, e, a} !== {1'b0, 1'b0, 4'h0, 1'b0, 4'hF}) begin
            failures++;
            $display("FAIL %s: busy=%b overrun=%b code=%h en=%b an=%b, required 0 0 0 0 1111",
                     name, b, ov, c, e, a);
        end
    endtask

    task automatic test_reset();
        exp_t z;
        z = model(8'd0, 1'b1);
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(1'b0, "reset_s");
        check_reset_outputs(1'b1, "reset_u");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (en_s !== 1'b0 || an_s !== 4'hF) begin
                failures++;
                $display("FAIL pre_wrap_%0d: en=%b an=%b, required 0 1111", i, en_s, an_s);
            end
        end
        check_display(1'b0, z, "reset_display");
    endtask

    task automatic test_positive();
        logic [7:0] vals [3];
        vals = '{8'd127, 8'd105, 8'd9};
        foreach (vals[i]) convert(1'b0, vals[i], $sformatf("pos_%0d", vals[i]));
    endtask

    task automatic test_negative();
        convert(1'b0, 8'h80, "neg_128");
        convert(1'b0, 8'hFF, "neg_1");
    endtask

    task automatic test_unsigned();
        convert(1'b1, 8'hFF, "uns_255");
        convert(1'b1, 8'h80, "uns_128");
    endtask

    // Second strobe lands 'delay' edges after an accepted one.
    task automatic test_overrun(input int delay, input logic [7:0] a_val,
                                input logic [7:0] c_val, input string name);
        int   n;
        exp_t e;
        send(1'b0, a_val, 1'b1);
        repeat (delay - 1) begin
            @(posedge clk); #1;
        end
        send(1'b0, 8'd99, 1'b0);
        checks++;
        if (ovr_s !== 1'b1) begin
            failures++;
            $display("FAIL %s_set: overrun=%b, required 1", name, ovr_s);
        end
        wait_idle(1'b0, name, n);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_sb: queue empty, required 1 entry", name);
        end else begin
            e = sb_q.pop_front();
            check_display(1'b0, e, {name, "_first"});
        end
        checks++;
        if (ovr_s !== 1'b1) begin
            failures++;
            $display("FAIL %s_sticky: overrun=%b, required 1", name, ovr_s);
        end
        send(1'b0, c_val, 1'b1);
        checks++;
        if (ovr_s !== 1'b0) begin
            failures++;
            $display("FAIL %s_clear: overrun=%b, required 0", name, ovr_s);
        end
        wait_idle(1'b0, name, n);
        e = sb_q.pop_front();
        check_display(1'b0, e, {name, "_next"});
    endtask

    task automatic test_reset_mid();
        exp_t z;
        z = model(8'd0, 1'b1);
        send(1'b0, 8'd200, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs(1'b0, "mid_reset_s");
        check_reset_outputs(1'b1, "mid_reset_u");
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_display(1'b0, z, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_unsigned();
        test_overrun(3, 8'd42, 8'hF6, "ovr_d3");
        test_overrun(10, 8'd200, 8'd0, "ovr_commit");
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
